// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit with HI/LO registers.
// Every operation takes 32 iteration cycles plus one finishing cycle.
// Multiply uses radix-2 shift-add and divide uses restoring division.
// Both work on operand magnitudes, and the sign is fixed up in the finishing cycle.
// Build option: define MDU_DIV_EN to include the divider. Without it,
// DIV/DIVU keep the same busy/done timing but leave HI/LO untouched.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [4:0]  count_reg;
    // acc_hi/acc_lo: product high/low half during multiply; remainder/quotient during divide
    logic [31:0] acc_hi_reg;
    logic [31:0] acc_lo_reg;
    // operand_reg: multiplicand magnitude, or divisor magnitude
    logic [31:0] operand_reg;
    logic        is_div_reg;
    logic        neg_q_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        accept;
    logic        step;
    logic        finish;
    logic        mt_en;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] product;
    logic [63:0] product_fix;

`ifdef MDU_DIV_EN
    logic [31:0] dividend_reg;
    logic        neg_r_reg;
    logic        div0_reg;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`endif

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Operand magnitudes: MULT and DIV (op[0]=0) are signed; MULTU and DIVU are unsigned
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];
    assign a_mag     = a_neg ? (~a + 32'd1) : a;
    assign b_mag     = b_neg ? (~b + 32'd1) : b;

    // One shift-add step: conditionally add the multiplicand into the high half
    assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : 33'd0);
    assign product     = {acc_hi_reg, acc_lo_reg};
    assign product_fix = neg_q_reg ? (~product + 64'd1) : product;

`ifdef MDU_DIV_EN
    // One restoring step: shift the next dividend bit into the remainder and trial-subtract
    assign div_shift = {acc_hi_reg, acc_lo_reg[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, operand_reg};
    assign quo_fix   = neg_q_reg ? (~acc_lo_reg + 32'd1) : acc_lo_reg;
    assign rem_fix   = neg_r_reg ? (~acc_hi_reg + 32'd1) : acc_hi_reg;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an unused encoding falls back to IDLE
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (count_reg == 5'd31) ? FIN : RUN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath enables
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        mt_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = start;
                mt_en  = ~start;
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            FIN: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Iteration datapath: capture operands on accept, then one step per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg   <= 5'd0;
            acc_hi_reg  <= 32'd0;
            acc_lo_reg  <= 32'd0;
            operand_reg <= 32'd0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
`ifdef MDU_DIV_EN
            dividend_reg <= 32'd0;
            neg_r_reg    <= 1'b0;
            div0_reg     <= 1'b0;
`endif
        end else if (accept) begin
            count_reg  <= 5'd0;
            acc_hi_reg <= 32'd0;
            is_div_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            operand_reg  <= op[1] ? b_mag : a_mag;
            acc_lo_reg   <= op[1] ? a_mag : b_mag;
            dividend_reg <= a;
            neg_r_reg    <= a_neg;
            div0_reg     <= (b == 32'd0);
`else
            operand_reg <= a_mag;
            acc_lo_reg  <= b_mag;
`endif
        end else if (step) begin
            count_reg <= count_reg + 5'd1;
`ifdef MDU_DIV_EN
            if (is_div_reg) begin
                acc_hi_reg <= div_diff[33] ? div_shift[31:0] : div_diff[31:0];
                acc_lo_reg <= {acc_lo_reg[30:0], ~div_diff[33]};
            end else begin
                {acc_hi_reg, acc_lo_reg} <= {mul_sum, acc_lo_reg[31:1]};
            end
`else
            {acc_hi_reg, acc_lo_reg} <= {mul_sum, acc_lo_reg[31:1]};
`endif
        end
    end

    // HI/LO update: result in the finishing cycle, mthi/mtlo only when idle and not starting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
            if (finish) begin
`ifdef MDU_DIV_EN
                if (is_div_reg) begin
                    if (div0_reg) begin
                        hi_reg <= dividend_reg;
                        lo_reg <= 32'hFFFF_FFFF;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end else begin
                    {hi_reg, lo_reg} <= product_fix;
                end
`else
                if (!is_div_reg) begin
                    {hi_reg, lo_reg} <= product_fix;
                end
`endif
            end else if (mt_en) begin
                if (mthi) begin
                    hi_reg <= wdata;
                end
                if (mtlo) begin
                    lo_reg <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit. Divide expectations follow MDU_DIV_EN.
// Without MDU_DIV_EN, divide operations are expected to leave HI/LO unchanged.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present an operation; start is sampled at the next edge
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic with_mthi);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        mthi  = with_mthi;
        wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
    endtask

    // Follow the operation to its done pulse and check timing and result
    task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input logic repulse);
        int lat;
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (repulse && i == 5) begin
                start = 1'b1;
                mthi  = 1'b1;
                wdata = 32'hDEAD_BEEF;
                op    = 2'b00;
                a     = 32'd3;
                b     = 32'd3;
            end
            if (repulse && i == 6) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            if (i == 1) begin
                check_eq({tag, " busy_run"}, 32'(busy), 32'd1);
                check_eq({tag, " done_low"}, 32'(done), 32'd0);
            end
            if (i == 16) begin
                check_eq({tag, " hi_hold"}, hi, model_hi);
                check_eq({tag, " lo_hold"}, lo, model_lo);
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, " latency"}, lat, 32'd33);
        check_eq({tag, " busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, " hi"}, hi, eh);
        check_eq({tag, " lo"}, lo, el);
        model_hi = eh;
        model_lo = el;
        $display("op %s latency=%0d hi=%08h lo=%08h", tag, lat, hi, lo);
    endtask

    task automatic div_case(input string tag, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                            input logic repulse);
        launch(o, x, y, 1'b0);
`ifdef MDU_DIV_EN
        finish_op(tag, eh, el, repulse);
`else
        finish_op(tag, model_hi, model_lo, repulse);
`endif
    endtask

    initial begin
        int done_count;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset hi", hi, 32'd0);
        check_eq("reset lo", lo, 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        $display("reset hi=%08h lo=%08h busy=%0d done=%0d", hi, lo, busy, done);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // mthi and mtlo together, then mthi alone
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hAABB_CCDD;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check_eq("mt_both hi", hi, 32'hAABB_CCDD);
        check_eq("mt_both lo", lo, 32'hAABB_CCDD);
        $display("mt_both hi=%08h lo=%08h", hi, lo);
        mthi  = 1'b1;
        wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check_eq("mthi hi", hi, 32'h1111_1111);
        check_eq("mthi lo", lo, 32'hAABB_CCDD);
        $display("mthi hi=%08h lo=%08h", hi, lo);
        model_hi = 32'h1111_1111;
        model_lo = 32'hAABB_CCDD;

        // Multiplies; each launch after the first lands in the previous done cycle
        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        finish_op("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        launch(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0);
        finish_op("mult_2p32", 32'h0000_0001, 32'h0000_0000, 1'b0);
        launch(2'b01, 32'd3, 32'd5, 1'b1);
        finish_op("multu_mthi_start", 32'h0000_0000, 32'h0000_000F, 1'b0);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op("mult_m1xm1", 32'h0000_0000, 32'h0000_0001, 1'b0);

        // Divides
        div_case("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        div_case("divu_100_0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
        div_case("divu_max_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        div_case("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        div_case("div_m8_0", 2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0);
        div_case("div_ovf_repulse", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                 32'h8000_0000, 1'b1);

        // Reset in the middle of a multiply aborts it, with start held during reset
        @(posedge clk);
        #1;
        launch(2'b00, 32'd5, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort hi", hi, 32'd0);
        check_eq("abort lo", lo, 32'd0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        $display("abort hi=%08h lo=%08h busy=%0d done=%0d", hi, lo, busy, done);
        rst_n = 1'b1;
        start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        check_eq("abort no_done", done_count, 32'd0);
        check_eq("abort idle_busy", 32'(busy), 32'd0);
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check_eq("mtlo_after_abort lo", lo, 32'h0000_1234);
        check_eq("mtlo_after_abort hi", hi, 32'd0);
        $display("mtlo_after_abort hi=%08h lo=%08h", hi, lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
